// File: rtl/lutram_fifo_ctrl_pkg.sv
// Shared definitions for the LUT-RAM FIFO controller: default sizes,
// the wrap-at-depth pointer increment and the per-cycle operation decode.
package lutram_fifo_ctrl_pkg;

    localparam int LFIFO_DEFAULT_DEPTH = 16;
    localparam int LFIFO_DEFAULT_DW    = 32;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_ENQ,
        OP_DEQ,
        OP_BOTH,
        OP_CLR
    } fifo_op_e;

    // Explicit wrap so non-power-of-two depths never touch unused entries.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/lutram_fifo_ctrl_if.sv
// Producer/consumer bundle of the LUT-RAM FIFO; master is the user side,
// slave is the FIFO controller.
interface lutram_fifo_ctrl_if #(
    parameter int data_width = 32,
    parameter int addr_width = 4
) ();

    // Handshake: an enqueue happens at a rising edge where ENQ && FULL_N, a
    // dequeue where DEQ && EMPTY_N; D_OUT holds the head whenever EMPTY_N=1.
    logic                  ENQ;
    logic [data_width-1:0] D_IN;
    logic                  FULL_N;
    logic                  DEQ;
    logic [data_width-1:0] D_OUT;
    logic                  EMPTY_N;
    logic                  CLR;
    logic [addr_width:0]   COUNT;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;

    modport master (
        output ENQ, D_IN, DEQ, CLR,
        input  FULL_N, D_OUT, EMPTY_N, COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  ENQ, D_IN, DEQ, CLR,
        output FULL_N, D_OUT, EMPTY_N, COUNT, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/lutram_fifo_ctrl_regfile.sv
// Distributed-RAM register file: one synchronous write port, five
// asynchronous read ports, entries lo..hi; contents are never reset.
module lutram_fifo_ctrl_regfile #(
    parameter int data_width = 32,
    parameter int addr_width = 4,
    parameter int lo         = 0,
    parameter int hi         = 15
) (
    input  logic                  clk,
    input  logic [addr_width-1:0] addr_in,
    input  logic [data_width-1:0] d_in,
    input  logic                  we,
    input  logic [addr_width-1:0] addr_1,
    input  logic [addr_width-1:0] addr_2,
    input  logic [addr_width-1:0] addr_3,
    input  logic [addr_width-1:0] addr_4,
    input  logic [addr_width-1:0] addr_5,
    output logic [data_width-1:0] d_out_1,
    output logic [data_width-1:0] d_out_2,
    output logic [data_width-1:0] d_out_3,
    output logic [data_width-1:0] d_out_4,
    output logic [data_width-1:0] d_out_5
);

    logic [data_width-1:0] mem [lo:hi];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr_in] <= d_in;
        end
    end

    assign d_out_1 = mem[addr_1];
    assign d_out_2 = mem[addr_2];
    assign d_out_3 = mem[addr_3];
    assign d_out_4 = mem[addr_4];
    assign d_out_5 = mem[addr_5];

endmodule

// File: rtl/lutram_fifo_ctrl.sv
// First-word-fall-through FIFO controller over the distributed RegFile:
// pointers, occupancy, full/empty flags and sticky overflow/underflow.
module lutram_fifo_ctrl
    import lutram_fifo_ctrl_pkg::*;
#(
    parameter int data_width = LFIFO_DEFAULT_DW,
    parameter int addr_width = 4,
    parameter int depth      = LFIFO_DEFAULT_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    lutram_fifo_ctrl_if.slave     fifo,
    output logic [addr_width-1:0] wr_ptr,
    output logic [addr_width-1:0] rd_ptr
);

    typedef logic [addr_width-1:0] ptr_t;
    typedef logic [addr_width:0]   count_t;

    count_t   count;
    logic     overflow;
    logic     underflow;
    logic     full_n;
    logic     empty_n;
    logic     enq_ok;
    logic     deq_ok;
    logic     we;
    fifo_op_e op;
    ptr_t     wr_ptr_next;
    ptr_t     rd_ptr_next;

    logic [data_width-1:0] d_out_1;
    logic [data_width-1:0] unused_d_out_2;
    logic [data_width-1:0] unused_d_out_3;
    logic [data_width-1:0] unused_d_out_4;
    logic [data_width-1:0] unused_d_out_5;

    // Flags are gated by RST_N so nothing is accepted while reset is held.
    assign full_n  = RST_N && (count != count_t'(depth));
    assign empty_n = RST_N && (count != '0);
    assign enq_ok  = fifo.ENQ && full_n;
    assign deq_ok  = fifo.DEQ && empty_n;
    assign we      = enq_ok && !fifo.CLR;

    assign wr_ptr_next = ptr_t'(ptr_next(32'(wr_ptr), depth));
    assign rd_ptr_next = ptr_t'(ptr_next(32'(rd_ptr), depth));

    always_comb begin
        op = OP_IDLE;
        if (fifo.CLR) begin
            op = OP_CLR;
        end else begin
            case ({enq_ok, deq_ok})
                2'b10:   op = OP_ENQ;
                2'b01:   op = OP_DEQ;
                2'b11:   op = OP_BOTH;
                default: op = OP_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (fifo.ENQ && !full_n) begin
                overflow <= 1'b1;
            end
            // A DEQ on empty paired with an accepted ENQ is a deferred read, not an error.
            if (fifo.DEQ && !empty_n && !enq_ok) begin
                underflow <= 1'b1;
            end
            case (op)
                OP_CLR: begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end
                OP_ENQ: begin
                    wr_ptr <= wr_ptr_next;
                    count  <= count + count_t'(1);
                end
                OP_DEQ: begin
                    rd_ptr <= rd_ptr_next;
                    count  <= count - count_t'(1);
                end
                OP_BOTH: begin
                    wr_ptr <= wr_ptr_next;
                    rd_ptr <= rd_ptr_next;
                end
                default: ;
            endcase
        end
    end

    lutram_fifo_ctrl_regfile #(
        .data_width (data_width),
        .addr_width (addr_width),
        .lo         (0),
        .hi         (depth - 1)
    ) storage (
        .clk     (CLK),
        .addr_in (wr_ptr),
        .d_in    (fifo.D_IN),
        .we      (we),
        .addr_1  (rd_ptr),
        .addr_2  ('0),
        .addr_3  ('0),
        .addr_4  ('0),
        .addr_5  ('0),
        .d_out_1 (d_out_1),
        .d_out_2 (unused_d_out_2),
        .d_out_3 (unused_d_out_3),
        .d_out_4 (unused_d_out_4),
        .d_out_5 (unused_d_out_5)
    );

    assign fifo.FULL_N    = full_n;
    assign fifo.EMPTY_N   = empty_n;
    assign fifo.D_OUT     = d_out_1;
    assign fifo.COUNT     = count;
    assign fifo.OVERFLOW  = overflow;
    assign fifo.UNDERFLOW = underflow;

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Bench for lutram_fifo_ctrl: a depth-16 instance and a depth-5 instance,
// checked against fixed vectors and a queue-based reference model.
module tb_lutram_fifo_ctrl;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    lutram_fifo_ctrl_if #(.data_width(32), .addr_width(4)) bus_a ();
    lutram_fifo_ctrl_if #(.data_width(32), .addr_width(3)) bus_b ();
    logic [3:0] wr_a, rd_a;
    logic [2:0] wr_b, rd_b;

    lutram_fifo_ctrl #(.data_width(32), .addr_width(4), .depth(16)) u_a (
        .CLK(CLK), .RST_N(RST_N), .fifo(bus_a), .wr_ptr(wr_a), .rd_ptr(rd_a)
    );
    lutram_fifo_ctrl #(.data_width(32), .addr_width(3), .depth(5)) u_b (
        .CLK(CLK), .RST_N(RST_N), .fifo(bus_b), .wr_ptr(wr_b), .rd_ptr(rd_b)
    );

    int checks = 0;
    int errors = 0;
    int sel = 0;
    logic [31:0] exp_q[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    typedef struct {
        bit          rst_n, enq, deq, clr;
        logic [31:0] din;
        bit          full_n, empty_n;
        int          cnt;
        bit          ovf, unf;
        logic [31:0] dout;
    } vec_t;
    vec_t vecs[16];

    function automatic int model_depth();
        return (sel == 0) ? 16 : 5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit enq, input bit deq, input bit clr, input logic [31:0] din);
        RST_N = rst;
        bus_a.ENQ = 0; bus_a.DEQ = 0; bus_a.CLR = 0; bus_a.D_IN = '0;
        bus_b.ENQ = 0; bus_b.DEQ = 0; bus_b.CLR = 0; bus_b.D_IN = '0;
        if (sel == 0) begin
            bus_a.ENQ = enq; bus_a.DEQ = deq; bus_a.CLR = clr; bus_a.D_IN = din;
        end else begin
            bus_b.ENQ = enq; bus_b.DEQ = deq; bus_b.CLR = clr; bus_b.D_IN = din;
        end
    endtask

    task automatic sample(output logic full_n, output logic empty_n, output logic [4:0] cnt,
                          output logic ovf, output logic unf, output logic [31:0] dout);
        if (sel == 0) begin
            full_n = bus_a.FULL_N; empty_n = bus_a.EMPTY_N; cnt = bus_a.COUNT;
            ovf = bus_a.OVERFLOW; unf = bus_a.UNDERFLOW; dout = bus_a.D_OUT;
        end else begin
            full_n = bus_b.FULL_N; empty_n = bus_b.EMPTY_N; cnt = {1'b0, bus_b.COUNT};
            ovf = bus_b.OVERFLOW; unf = bus_b.UNDERFLOW; dout = bus_b.D_OUT;
        end
    endtask

    // Reference model: a plain queue of held entries plus two sticky bits.
    task automatic model_step(input bit rst, input bit enq, input bit deq, input bit clr, input logic [31:0] din);
        bit has_room, has_data;
        logic [31:0] tmp;
        if (!rst) begin
            exp_q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            has_room = exp_q.size() != model_depth();
            has_data = exp_q.size() != 0;
            if (enq && !has_room) m_ovf = 1;
            if (deq && !has_data && !(enq && has_room)) m_unf = 1;
            if (clr) begin
                exp_q.delete();
            end else begin
                if (deq && has_data) tmp = exp_q.pop_front();
                if (enq && has_room) exp_q.push_back(din);
            end
        end
    endtask

    task automatic check_model(input string name);
        logic f, e, o, u;
        logic [4:0] c;
        logic [31:0] d;
        sample(f, e, c, o, u, d);
        chk({name, ".full_n"}, f, RST_N && (exp_q.size() != model_depth()));
        chk({name, ".empty_n"}, e, RST_N && (exp_q.size() != 0));
        chk({name, ".count"}, c, exp_q.size());
        chk({name, ".overflow"}, o, m_ovf);
        chk({name, ".underflow"}, u, m_unf);
        if (RST_N && exp_q.size() != 0) chk({name, ".d_out"}, d, exp_q[0]);
        if (sel == 1) begin
            chk({name, ".wr_ptr_le_4"}, wr_b <= 3'd4, 1);
            chk({name, ".rd_ptr_le_4"}, rd_b <= 3'd4, 1);
        end
    endtask

    task automatic cyc(input string name, input bit rst, input bit enq, input bit deq, input bit clr, input logic [31:0] din);
        drive(rst, enq, deq, clr, din);
        #1;
        check_model(name);
        @(posedge CLK);
        model_step(rst, enq, deq, clr, din);
        #1;
    endtask

    task automatic reset_active(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0);
            @(posedge CLK);
            model_step(0, 0, 0, 0, 0);
            #1;
        end
    endtask

    logic f_s, e_s, o_s, u_s;
    logic [4:0] c_s;
    logic [31:0] d_s;

    initial begin
        drive(0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        reset_active(2);

        // rst_n enq deq clr din | full_n empty_n cnt ovf unf dout (values seen before the edge)
        vecs[0]  = '{0, 1, 1, 0, 32'h11, 0, 0, 0, 0, 0, 32'h0};
        vecs[1]  = '{0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0};
        vecs[2]  = '{1, 0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0};
        vecs[3]  = '{1, 1, 1, 0, 32'hA5, 1, 0, 0, 0, 0, 32'h0};
        vecs[4]  = '{1, 0, 0, 0, 32'h0,  1, 1, 1, 0, 0, 32'hA5};
        vecs[5]  = '{1, 1, 0, 0, 32'hB6, 1, 1, 1, 0, 0, 32'hA5};
        vecs[6]  = '{1, 0, 1, 0, 32'h0,  1, 1, 2, 0, 0, 32'hA5};
        vecs[7]  = '{1, 0, 0, 0, 32'h0,  1, 1, 1, 0, 0, 32'hB6};
        vecs[8]  = '{1, 0, 1, 0, 32'h0,  1, 1, 1, 0, 0, 32'hB6};
        vecs[9]  = '{1, 0, 1, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0};
        vecs[10] = '{1, 0, 0, 0, 32'h0,  1, 0, 0, 0, 1, 32'h0};
        vecs[11] = '{1, 1, 0, 0, 32'hC3, 1, 0, 0, 0, 1, 32'h0};
        vecs[12] = '{1, 1, 0, 1, 32'h55, 1, 1, 1, 0, 1, 32'hC3};
        vecs[13] = '{1, 0, 0, 0, 32'h0,  1, 0, 0, 0, 1, 32'h0};
        vecs[14] = '{0, 0, 1, 0, 32'h0,  0, 0, 0, 0, 1, 32'h0};
        vecs[15] = '{1, 0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0};

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst_n, vecs[i].enq, vecs[i].deq, vecs[i].clr, vecs[i].din);
            #1;
            sample(f_s, e_s, c_s, o_s, u_s, d_s);
            chk($sformatf("vec%0d.full_n", i), f_s, vecs[i].full_n);
            chk($sformatf("vec%0d.empty_n", i), e_s, vecs[i].empty_n);
            chk($sformatf("vec%0d.count", i), c_s, vecs[i].cnt);
            chk($sformatf("vec%0d.overflow", i), o_s, vecs[i].ovf);
            chk($sformatf("vec%0d.underflow", i), u_s, vecs[i].unf);
            if (vecs[i].empty_n) chk($sformatf("vec%0d.d_out", i), d_s, vecs[i].dout);
            @(posedge CLK);
            model_step(vecs[i].rst_n, vecs[i].enq, vecs[i].deq, vecs[i].clr, vecs[i].din);
            #1;
        end

        // Fill to 16, overflow on the 17th, then drain in order.
        for (int i = 0; i < 16; i++) cyc("fill", 1, 1, 0, 0, i);
        drive(1, 0, 0, 0, 0); #1;
        sample(f_s, e_s, c_s, o_s, u_s, d_s);
        chk("full_n_at_16", f_s, 0);
        chk("count_at_16", c_s, 16);
        @(posedge CLK); model_step(1, 0, 0, 0, 0); #1;
        cyc("enq_17th", 1, 1, 0, 0, 32'hFF);
        drive(1, 0, 0, 0, 0); #1;
        sample(f_s, e_s, c_s, o_s, u_s, d_s);
        chk("overflow_17th", o_s, 1);
        chk("count_after_drop", c_s, 16);
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 1, 0, 0); #1;
            sample(f_s, e_s, c_s, o_s, u_s, d_s);
            chk($sformatf("drain%0d", i), d_s, i);
            @(posedge CLK); model_step(1, 0, 1, 0, 0); #1;
        end
        drive(1, 0, 0, 0, 0); #1;
        sample(f_s, e_s, c_s, o_s, u_s, d_s);
        chk("empty_after_drain", e_s, 0);

        // Simultaneous ENQ+DEQ at count 3 holds occupancy.
        for (int i = 0; i < 3; i++) cyc("pre3", 1, 1, 0, 0, 32'h100 + i);
        for (int i = 0; i < 10; i++) begin
            cyc("both3", 1, 1, 1, 0, 32'h200 + i);
            chk("count_held_3", bus_a.COUNT, 3);
        end
        for (int i = 0; i < 3; i++) cyc("post3", 1, 0, 1, 0, 0);

        // Simultaneous ENQ+DEQ on empty: only the enqueue takes effect.
        cyc("both_empty", 1, 1, 1, 0, 32'hA5);
        drive(1, 0, 0, 0, 0); #1;
        sample(f_s, e_s, c_s, o_s, u_s, d_s);
        chk("both_empty.underflow", u_s, 0);
        chk("both_empty.count", c_s, 1);
        chk("both_empty.d_out", d_s, 32'hA5);
        @(posedge CLK); model_step(1, 0, 0, 0, 0); #1;
        cyc("drain_a5", 1, 0, 1, 0, 0);

        // CLR beats a concurrent ENQ.
        for (int i = 0; i < 7; i++) cyc("pre7", 1, 1, 0, 0, 32'h300 + i);
        cyc("clr_enq", 1, 1, 0, 1, 32'h55);
        drive(1, 0, 0, 0, 0); #1;
        sample(f_s, e_s, c_s, o_s, u_s, d_s);
        chk("clr.count", c_s, 0);
        chk("clr.empty_n", e_s, 0);
        @(posedge CLK); model_step(1, 0, 0, 0, 0); #1;
        cyc("enq_77", 1, 1, 0, 0, 32'h77);
        drive(1, 0, 0, 0, 0); #1;
        sample(f_s, e_s, c_s, o_s, u_s, d_s);
        chk("clr.head_77", d_s, 32'h77);
        @(posedge CLK); model_step(1, 0, 0, 0, 0); #1;

        // Reset mid-operation at count 9, then underflow.
        for (int i = 0; i < 8; i++) cyc("pre9", 1, 1, 0, 0, 32'h400 + i);
        chk("ovf_latched_before_reset", bus_a.OVERFLOW, 1);
        cyc("mid_reset", 0, 1, 1, 0, 32'hEE);
        drive(1, 0, 0, 0, 0); #1;
        sample(f_s, e_s, c_s, o_s, u_s, d_s);
        chk("mid_reset.count", c_s, 0);
        chk("mid_reset.empty_n", e_s, 0);
        chk("mid_reset.overflow", o_s, 0);
        @(posedge CLK); model_step(1, 0, 0, 0, 0); #1;
        cyc("deq_empty", 1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0); #1;
        sample(f_s, e_s, c_s, o_s, u_s, d_s);
        chk("underflow_set", u_s, 1);
        @(posedge CLK); model_step(1, 0, 0, 0, 0); #1;

        // Randomized traffic on the depth-16 instance.
        for (int i = 0; i < 400; i++) begin
            cyc("rand_a", $urandom_range(0, 99) != 0, $urandom_range(0, 99) < 60,
                $urandom_range(0, 99) < 45, $urandom_range(0, 59) == 0, $urandom());
        end

        // Depth-5 instance: interleaved push/pop across several wraps.
        sel = 1;
        reset_active(2);
        for (int i = 0; i < 24; i++) begin
            cyc("wrap5", 1, (i < 18) && (i % 3 != 2), (i >= 2) && (i % 3 != 0), 0, 32'h500 + i);
        end
        for (int i = 0; i < 6; i++) cyc("wrap5_drain", 1, 0, 1, 0, 0);
        for (int i = 0; i < 400; i++) begin
            cyc("rand_b", $urandom_range(0, 99) != 0, $urandom_range(0, 99) < 55,
                $urandom_range(0, 99) < 50, $urandom_range(0, 59) == 0, $urandom());
        end
        drive(1, 0, 0, 0, 0); #1;
        check_model("final_b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
